// File: rtl/oe_pkg.sv
// oe_pkg: shared defaults and arithmetic helpers for the output-error stage.
package oe_pkg;

  localparam int DEF_W   = 10;
  localparam int DEF_WIN = 16;

  // Width of the windowed |e| accumulator. It holds WIN * 2^(W-1) without overflow.
  function automatic int acc_width(input int w, input int win);
    return w + $clog2(win);
  endfunction

  // Magnitude of a signed value, returned unsigned so that |most-negative| is representable.
  function automatic logic [31:0] abs_signed(input logic signed [31:0] x);
    if (x < 32'sd0) begin
      return $unsigned(-x);
    end else begin
      return $unsigned(x);
    end
  endfunction

  // Clamp a signed value to the w-bit two's complement range.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/cpa_resolve.sv
// cpa_resolve: carry-propagate resolution of a carry-save pair, returning (sum+carry)>>1
// truncated to W bits (mod 2^W). Reusable by any error stage fed from a carry-save tree.
module cpa_resolve #(
  parameter int W = 10
) (
  input  logic [W:0]   sum,
  input  logic [W:0]   carry,
  output logic [W-1:0] y
);

  // Only bits [W:1] of the full sum are kept, so the adder's carry-out never matters.
  assign y = W'((sum + carry) >> 1);

endmodule

// File: rtl/oe_pipe.sv
// oe_pipe: two-stage pipelined output/error stage with valid/ready flow control and a
// windowed absolute-error accumulator.
// Build option: define OE_SAT_EN to saturate the error subtract instead of wrapping mod 2^W.
module oe_pipe
  import oe_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int WIN   = DEF_WIN,
  parameter int ACC_W = acc_width(W, WIN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W:0]       sum,
  input  logic [W:0]       carry,
  input  logic [W-1:0]     d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     y,
  output logic [W-1:0]     e,
  input  logic             clr,
  output logic [ACC_W-1:0] err_acc,
  output logic             err_acc_valid
);

  localparam int CW = $clog2(WIN);

  logic             adv1_s;
  logic             adv2_s;
  logic             accept_s;
  logic             out_hs_s;
  logic [W-1:0]     y1_s;
  logic [W-1:0]     e_next_s;
  logic [W-1:0]     e_abs_s;
  logic             s1_valid_r;
  logic             s2_valid_r;
  logic [W-1:0]     y1_r;
  logic [W-1:0]     d1_r;
  logic [W-1:0]     y_r;
  logic [W-1:0]     e_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] err_acc_r;
  logic [CW-1:0]    cnt_r;
  logic             err_acc_valid_r;

  cpa_resolve #(.W(W)) u_cpa (
    .sum   (sum),
    .carry (carry),
    .y     (y1_s)
  );

  // A stage may load when it is empty or its successor is moving; in_ready never looks at in_valid.
  assign adv2_s   = !s2_valid_r || out_ready;
  assign adv1_s   = !s1_valid_r || adv2_s;
  assign in_ready = adv1_s;
  assign accept_s = in_valid && adv1_s;
  assign out_hs_s = s2_valid_r && out_ready;

  assign out_valid     = s2_valid_r;
  assign y             = y_r;
  assign e             = e_r;
  assign err_acc       = err_acc_r;
  assign err_acc_valid = err_acc_valid_r;

`ifdef OE_SAT_EN
  logic signed [W:0] diff_s;
  assign diff_s = $signed({d1_r[W-1], d1_r}) - $signed({y1_r[W-1], y1_r});
`endif

  // Stage-2 error value: either saturated W+1-bit difference or legacy mod-2^W wrap.
  always_comb begin
    e_next_s = {W{1'b0}};
`ifdef OE_SAT_EN
    e_next_s = W'(sat_signed(32'(diff_s), W));
`else
    e_next_s = d1_r - y1_r;
`endif
  end

  // Magnitude of the registered error, read as signed.
  always_comb begin
    e_abs_s = W'(abs_signed(32'(signed'(e_r))));
  end

  // Stage 1: capture resolved y and the matching desired sample on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      y1_r       <= {W{1'b0}};
      d1_r       <= {W{1'b0}};
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        y1_r <= y1_s;
        d1_r <= d;
      end
    end
  end

  // Stage 2: register the output pair when the stage advances with a valid stage-1 sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      y_r        <= {W{1'b0}};
      e_r        <= {W{1'b0}};
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        y_r <= y1_r;
        e_r <= e_next_s;
      end
    end
  end

  // Window accumulator: sum |e| per output handshake, publish every WIN samples; clr wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r           <= {ACC_W{1'b0}};
      cnt_r           <= {CW{1'b0}};
      err_acc_r       <= {ACC_W{1'b0}};
      err_acc_valid_r <= 1'b0;
    end else begin
      err_acc_valid_r <= 1'b0;
      if (clr) begin
        acc_r <= {ACC_W{1'b0}};
        cnt_r <= {CW{1'b0}};
      end else if (out_hs_s) begin
        if (cnt_r == CW'(WIN - 1)) begin
          err_acc_r       <= acc_r + ACC_W'(e_abs_s);
          err_acc_valid_r <= 1'b1;
          acc_r           <= {ACC_W{1'b0}};
          cnt_r           <= {CW{1'b0}};
        end else begin
          acc_r <= acc_r + ACC_W'(e_abs_s);
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_oe_pipe.sv
// tb_oe_pipe: self-checking bench for oe_pipe (W=10, WIN=4) against a queue-based
// transaction model. Honours OE_SAT_EN in its expectations when that macro is defined.
module tb_oe_pipe;

  localparam int W     = 10;
  localparam int WIN   = 4;
  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W:0]       sum;
  logic [W:0]       carry;
  logic [W-1:0]     d;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     y;
  logic [W-1:0]     e;
  logic             clr;
  logic [ACC_W-1:0] err_acc;
  logic             err_acc_valid;

  oe_pipe #(.W(W), .WIN(WIN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sum           (sum),
    .carry         (carry),
    .d             (d),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .y             (y),
    .e             (e),
    .clr           (clr),
    .err_acc       (err_acc),
    .err_acc_valid (err_acc_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int e;
    int vis;   // first edge count after which this sample may be at the output
  } item_t;

  item_t q[$];        // accepted samples not yet handed off, oldest first
  int    win_q[$];    // |e| values of the current, unfinished window
  int    edge_n    = 0;
  int    n_tests   = 0;
  int    n_fail    = 0;
  int    err_acc_m = 0;
  bit    pulse_m   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_y(input int s, input int c);
    return ((s + c) / 2) % 1024;
  endfunction

  function automatic int as_signed(input int v);
    return (v >= 512) ? v - 1024 : v;
  endfunction

  function automatic int model_e(input int dv, input int yv);
    int diff;
    diff = as_signed(dv) - as_signed(yv);
`ifdef OE_SAT_EN
    if (diff > 511) diff = 511;
    if (diff < -512) diff = -512;
`endif
    return diff & 1023;
  endfunction

  function automatic int mag(input int v);
    return (v >= 512) ? 1024 - v : v;
  endfunction

  // One clock cycle: check current outputs, drive inputs, advance the model across the edge.
  task automatic step(input bit iv, input int s, input int c, input int dv,
                      input bit ordy, input bit cl, output bit accepted);
    bit    ov_m;
    bit    ir_m;
    bit    hs;
    int    total;
    item_t it;
    ov_m = (q.size() > 0) && (q[0].vis <= edge_n);
    check_val("out_valid", out_valid, ov_m);
    if (ov_m) begin
      check_val("y", y, q[0].y);
      check_val("e", e, q[0].e);
    end
    check_val("err_acc_valid", err_acc_valid, pulse_m);
    check_val("err_acc", err_acc, err_acc_m);
    in_valid  = iv;
    sum       = s[W:0];
    carry     = c[W:0];
    d         = dv[W-1:0];
    out_ready = ordy;
    clr       = cl;
    #1;
    ir_m = !(q.size() >= 2 && !ordy);
    check_val("in_ready", in_ready, ir_m);
    accepted = iv && ir_m;
    hs       = ov_m && ordy;
    pulse_m  = 1'b0;
    if (cl) begin
      win_q.delete();
    end else if (hs) begin
      win_q.push_back(mag(q[0].e));
      if (win_q.size() == WIN) begin
        total = 0;
        foreach (win_q[k]) total += win_q[k];
        err_acc_m = total;
        pulse_m   = 1'b1;
        win_q.delete();
      end
    end
    if (hs) void'(q.pop_front());
    if (accepted) begin
      it.y   = model_y(s, c);
      it.e   = model_e(dv, it.y);
      it.vis = edge_n + 2;
      q.push_back(it);
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b1, 1'b0, a);
  endtask

  task automatic feed(input int dv, input bit cl);
    bit a;
    step(1'b1, 0, 0, dv, 1'b1, cl, a);
  endtask

  // One-cycle reset, then confirm every output is cleared.
  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    win_q.delete();
    err_acc_m = 0;
    pulse_m   = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_y", y, 10'd0);
    check_val("rst_e", e, 10'd0);
    check_val("rst_err_acc", err_acc, 12'd0);
    check_val("rst_err_acc_valid", err_acc_valid, 1'b0);
    check_val("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    bit a;
    bit saw_low;
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    sum       = 11'd0;
    carry     = 11'd0;
    d         = 10'd0;
    @(negedge clk);
    do_reset();

    // Basic: y = (6+4)>>1 = 5, e = 12-5 = 7
    step(1'b1, 6, 4, 12, 1'b1, 1'b0, a);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0, a);
    check_val("basic_valid", out_valid, 1'b1);
    check_val("basic_y", y, 10'd5);
    check_val("basic_e", e, 10'd7);
    idle(2);

    // Wrap cases
    step(1'b1, 11'h7FF, 11'h7FF, 0, 1'b1, 1'b0, a);
    step(1'b1, 11'h400, 0, 10'h1FF, 1'b1, 1'b0, a);
    check_val("wrap_y0", y, 10'h3FF);
    check_val("wrap_e0", e, 10'h001);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0, a);
    check_val("wrap_y1", y, 10'h200);
`ifdef OE_SAT_EN
    check_val("wrap_e1", e, 10'h1FF);
`else
    check_val("wrap_e1", e, 10'h3FF);
`endif
    idle(2);

    // Backpressure: four samples, output stalled for the first three cycles
    saw_low = 1'b0;
    cyc     = 0;
    for (int i = 0; i < 4; i++) begin
      a = 1'b0;
      while (!a && cyc < 40) begin
        step(1'b1, 2 * (i + 1), 0, 0, (cyc >= 3), 1'b0, a);
        if (!in_ready) saw_low = 1'b1;
        cyc++;
      end
    end
    check_val("bp_in_ready_fell", saw_low, 1'b1);
    check_val("bp_cycle_budget", (cyc < 40), 1'b1);
    idle(4);
    check_val("bp_drained", out_valid, 1'b0);

    // Window: e = 3, -2, 5, -1 -> 11
    do_reset();
    feed(3, 1'b0);
    feed(10'h3FE, 1'b0);
    feed(5, 1'b0);
    feed(10'h3FF, 1'b0);
    idle(2);
    check_val("win_pulse", err_acc_valid, 1'b1);
    check_val("win_acc", err_acc, 12'd11);
    idle(1);
    check_val("win_pulse_once", err_acc_valid, 1'b0);
    for (int i = 0; i < 4; i++) feed(1, 1'b0);
    idle(2);
    check_val("win2_acc", err_acc, 12'd4);

    // clr on the final handshake of a window
    idle(1);
    for (int i = 0; i < 4; i++) feed(2, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0, a);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1, a);
    check_val("clr_no_pulse", err_acc_valid, 1'b0);
    check_val("clr_acc_hold", err_acc, 12'd4);
    idle(1);
    for (int i = 0; i < 4; i++) feed(3, 1'b0);
    idle(2);
    check_val("clr_next_pulse", err_acc_valid, 1'b1);
    check_val("clr_next_acc", err_acc, 12'd12);

    // Reset with both stages full
    step(1'b1, 20, 2, 7, 1'b0, 1'b0, a);
    step(1'b1, 30, 2, 9, 1'b0, 1'b0, a);
    check_val("pre_rst_full", in_ready, 1'b0);
    do_reset();
    idle(3);
    check_val("post_rst_no_stale", out_valid, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 2047), $urandom_range(0, 2047),
           $urandom_range(0, 1023), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 31) == 0), a);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
